cell_reader: RTL and testbench
==============================

# cell_reader

Read-side companion to the 5x5 sprite drawing path. Given a maze tile coordinate on the 32x24 tile grid, the block scans the 25 pixels of that 5x5 cell from the shadow framebuffer RAM (160x120, 3-bit colour). It then reports pixel counts, an occupancy mask and a wall classification. The movement controller uses it to decide whether pacman may enter a tile before the sprite is redrawn there.

## Interface
Parameters:
- WALL_COLOUR, 3'b001, colour code that counts as wall
- WALL_THRESH, 5'd13, minimum wall-pixel count for is_wall=1

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  synchronous, active-low reset
- req  in  1  start a scan; sampled only in IDLE
- x_in  in  8  tile column, valid 0..31
- y_in  in  7  tile row, valid 0..23
- rd_en  out  1  framebuffer read strobe
- rd_addr  out  15  pixel address = y_pix*160 + x_pix
- rd_data  in  3  pixel colour, valid one cycle after rd_en
- busy  out  1  scan in progress, req ignored
- done  out  1  one-cycle pulse, results valid
- range_err  out  1  last request was outside the tile grid
- wall_count  out  5  pixels equal to WALL_COLOUR (0..25)
- nonzero_count  out  5  pixels not equal to 3'b000 (0..25)
- cell_mask  out  25  bit 24-(row*5+col) set when that pixel is nonzero
- is_wall  out  1  wall_count >= WALL_THRESH, or range_err

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE, ERR.
- IDLE with req=1 and x_in<=31, y_in<=23:
  - latch x_base=x_in*5 and y_base=y_in*5
  - clear accumulators and the loc counter
  - go to SCAN
- IDLE with req=1 and an out-of-range coordinate: go to ERR. No reads are issued.
- SCAN:
  - rd_en=1
  - rd_addr=(y_base+loc[5:3])*160 + x_base+loc[2:0]
  - loc[2:0] counts 0..4 as the column. On reaching 4 it wraps to 0 and loc[5:3] increments as the row.
  - After 6'b100100, go to DRAIN.
- Accumulate pipeline: a registered copy of loc travels alongside each read. When the returning rd_data is valid:
  - increment wall_count if rd_data==WALL_COLOUR
  - increment nonzero_count if rd_data!=0
  - set the matching cell_mask bit if rd_data!=0
- DRAIN: rd_en=0; accumulate the final sample, then go to DONE.
- DONE: done=1, is_wall and range_err=0 update, go to IDLE.
- ERR: done=1, range_err=1, is_wall=1, counts=0, mask=0, go to IDLE.
- Result outputs hold their values from the done cycle until the next accepted req.
- Address arithmetic:
  - all internal terms are 15 bits wide
  - maximum address is 19199; no overflow is possible
- Reset values:
  - state=IDLE
  - rd_en, busy, done, range_err and is_wall = 0
  - rd_addr=0, counts=0, cell_mask=0
- Reset mid-scan returns to IDLE immediately and discards the partial results.

## Timing
- Accept edge A (IDLE, req=1). rd_en is high for cycles A+1..A+25, exactly 25 consecutive cycles.
- DRAIN occupies cycle A+26 and done is high in cycle A+27. Latency from accept to done is 27 cycles.
- busy is high for cycles A+1..A+27.
- A req held high gives back-to-back scans with a 28-cycle period.
- Out-of-range request: ERR occupies cycle A+1, done=1 and busy=1 in that cycle, and rd_en is never asserted.
- RAM read latency is fixed at 1 cycle and no stall is supported.

## Configuration
- CELL_READER_MASK_EN
  - Defined: the cell_mask register and its update logic are built as described above.
  - Undefined: cell_mask is tied to 25'd0 and its logic is removed. The port remains, and counts, is_wall, timing and done behaviour are unchanged.

## Test plan
- All-zero RAM, req at (0,0):
  - rd_addr sequence is 0,1,2,3,4,160..164,...,640..644
  - done at A+27
  - wall_count=0, nonzero_count=0, is_wall=0
- RAM filled with 3'b001, req at (31,23):
  - first rd_addr=18555, last rd_addr=19199
  - wall_count=25, nonzero_count=25, is_wall=1
  - cell_mask=25'h1FFFFFF
- Cell (4,3) preloaded with pattern 0111011111110001111101110 in colour 3'b110:
  - nonzero_count=18, wall_count=0, is_wall=0
  - cell_mask=25'b0111011111110001111101110 (with CELL_READER_MASK_EN)
  - cell_mask=0 (without CELL_READER_MASK_EN)
- Threshold boundary with 12 vs 13 wall pixels in a cell: is_wall=0 and is_wall=1 respectively.
- req at (32,5), then at (0,24):
  - no rd_en
  - done at A+1 with range_err=1, is_wall=1, counts=0
- reset_n low at cycle A+10 of a scan:
  - next cycle shows IDLE, all outputs at reset values, no done
  - a following req runs a full 27-cycle scan with correct counts

Source files
------------

// File: rtl/cell_reader_if.sv
// cell_reader_if
//   Bundles the request, framebuffer read port and result signals of the
//   5x5 cell reader.
//   master : requester / framebuffer side (drives req, x_in, y_in, rd_data)
//   slave  : cell_reader side (drives read strobe/address, status, results)
//   Signals:
//     req, x_in[7:0], y_in[6:0]          scan request and tile coordinate
//     rd_en, rd_addr[14:0], rd_data[2:0] framebuffer read port
//     busy, done, range_err              status
//     wall_count[4:0], nonzero_count[4:0], cell_mask[24:0], is_wall  results
interface cell_reader_if;
  logic        req;
  logic [7:0]  x_in;
  logic [6:0]  y_in;
  logic        rd_en;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data;
  logic        busy;
  logic        done;
  logic        range_err;
  logic [4:0]  wall_count;
  logic [4:0]  nonzero_count;
  logic [24:0] cell_mask;
  logic        is_wall;

  modport master (
    output req, x_in, y_in, rd_data,
    input  rd_en, rd_addr, busy, done, range_err,
           wall_count, nonzero_count, cell_mask, is_wall
  );

  modport slave (
    input  req, x_in, y_in, rd_data,
    output rd_en, rd_addr, busy, done, range_err,
           wall_count, nonzero_count, cell_mask, is_wall
  );
endinterface

// File: rtl/cell_reader.sv
// cell_reader
//   Scans the 25 pixels of one 5x5 maze cell from the shadow framebuffer
//   (160x120, 3-bit colour) and reports wall/nonzero pixel counts, an
//   occupancy mask and a wall classification.
//   Ports:
//     clock    system clock
//     reset_n  synchronous, active-low reset
//     bus      cell_reader_if.slave (request, read port, results)
//   Build option:
//     CELL_READER_MASK_EN  defined   -> cell_mask register is built
//                          undefined -> cell_mask tied to zero
module cell_reader #(
  parameter logic [2:0] WALL_COLOUR = 3'b001,
  parameter logic [4:0] WALL_THRESH = 5'd13
) (
  input logic         clock,
  input logic         reset_n,
  cell_reader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DONE, ERR} state_t;

  localparam logic [5:0] LOC_LAST = 6'b100100;

  state_t      state_q, state_d;
  logic [5:0]  loc_q, loc_d;
  logic [14:0] xb_q, xb_d;
  logic [14:0] yb_q, yb_d;
  logic [4:0]  wall_q, wall_d;
  logic [4:0]  nz_q, nz_d;
  logic        rerr_q, rerr_d;
  logic        iswall_q, iswall_d;
  logic        vld_p0;
  logic        scan;
  logic        in_range;
  logic [14:0] addr;

`ifdef CELL_READER_MASK_EN
  logic [24:0] mask_q, mask_d;
  logic [5:0]  loc_p0;

  // Pixel (row,col) maps to mask bit 24-(row*5+col): row 0, col 0 is the MSB.
  function automatic logic [4:0] mask_bit(input logic [5:0] loc);
    return 5'd24 - ({2'b00, loc[5:3]} * 5'd5 + {2'b00, loc[2:0]});
  endfunction
`endif

  assign scan     = (state_q == SCAN);
  assign in_range = (bus.x_in <= 8'd31) && (bus.y_in <= 7'd23);
  assign addr     = (yb_q + {12'd0, loc_q[5:3]}) * 15'd160 + xb_q + {12'd0, loc_q[2:0]};

  assign bus.rd_en         = scan;
  assign bus.rd_addr       = scan ? addr : 15'd0;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE) || (state_q == ERR);
  assign bus.range_err     = rerr_q;
  assign bus.is_wall       = iswall_q;
  assign bus.wall_count    = wall_q;
  assign bus.nonzero_count = nz_q;
`ifdef CELL_READER_MASK_EN
  assign bus.cell_mask     = mask_q;
`else
  assign bus.cell_mask     = 25'd0;
`endif

  always_comb begin
    state_d  = state_q;
    loc_d    = loc_q;
    xb_d     = xb_q;
    yb_d     = yb_q;
    wall_d   = wall_q;
    nz_d     = nz_q;
    rerr_d   = rerr_q;
    iswall_d = iswall_q;
`ifdef CELL_READER_MASK_EN
    mask_d   = mask_q;
`endif

    // Sample returning from the read issued one cycle earlier.
    if (vld_p0) begin
      if (bus.rd_data == WALL_COLOUR) wall_d = wall_q + 5'd1;
      if (bus.rd_data != 3'b000) begin
        nz_d = nz_q + 5'd1;
`ifdef CELL_READER_MASK_EN
        mask_d[mask_bit(loc_p0)] = 1'b1;
`endif
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          wall_d = 5'd0;
          nz_d   = 5'd0;
`ifdef CELL_READER_MASK_EN
          mask_d = 25'd0;
`endif
          if (in_range) begin
            xb_d     = {7'd0, bus.x_in} * 15'd5;
            yb_d     = {8'd0, bus.y_in} * 15'd5;
            loc_d    = 6'd0;
            rerr_d   = 1'b0;
            iswall_d = 1'b0;
            state_d  = SCAN;
          end else begin
            rerr_d   = 1'b1;
            iswall_d = 1'b1;
            state_d  = ERR;
          end
        end
      end
      SCAN: begin
        if (loc_q == LOC_LAST) begin
          state_d = DRAIN;
        end else if (loc_q[2:0] == 3'd4) begin
          loc_d = {loc_q[5:3] + 3'd1, 3'd0};
        end else begin
          loc_d = {loc_q[5:3], loc_q[2:0] + 3'd1};
        end
      end
      DRAIN: begin
        // wall_d already includes the final sample accumulated this cycle.
        iswall_d = (wall_d >= WALL_THRESH);
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      loc_q    <= 6'd0;
      wall_q   <= 5'd0;
      nz_q     <= 5'd0;
      rerr_q   <= 1'b0;
      iswall_q <= 1'b0;
      vld_p0   <= 1'b0;
`ifdef CELL_READER_MASK_EN
      mask_q   <= 25'd0;
`endif
    end else begin
      loc_q    <= loc_d;
      wall_q   <= wall_d;
      nz_q     <= nz_d;
      rerr_q   <= rerr_d;
      iswall_q <= iswall_d;
      vld_p0   <= scan;
`ifdef CELL_READER_MASK_EN
      mask_q   <= mask_d;
`endif
    end
  end

  // ---- p0: read issued; loc travels with the outstanding read ----
  always_ff @(posedge clock) begin
    xb_q <= xb_d;
    yb_q <= yb_d;
`ifdef CELL_READER_MASK_EN
    loc_p0 <= loc_q;
`endif
  end

endmodule

// File: tb/tb_cell_reader.sv
module tb_cell_reader;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cell_reader_if bus();
  cell_reader dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  logic [2:0] mem [0:19199];
  always @(posedge clock) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  // Results gathered by do_scan
  int          rd_cnt, addr_bad, busy_bad, done_cyc, first_rd, last_rd;
  int          first_addr, last_addr;
  logic [4:0]  r_wall, r_nz;
  logic [24:0] r_mask;
  logic        r_iswall, r_rerr, post_done;
  logic [4:0]  post_wall;

  task automatic fill(input logic [2:0] v);
    for (int i = 0; i < 19200; i++) mem[i] = v;
  endtask

  task automatic set_cell(input int x, input int y, input logic [24:0] pat, input logic [2:0] col);
    for (int i = 0; i < 25; i++)
      mem[(y*5 + i/5)*160 + x*5 + i%5] = pat[24-i] ? col : 3'b000;
  endtask

  task automatic do_scan(input int x, input int y);
    int ea;
    @(negedge clock);
    bus.req = 1'b1; bus.x_in = x[7:0]; bus.y_in = y[6:0];
    @(posedge clock);
    rd_cnt = 0; addr_bad = 0; busy_bad = 0; done_cyc = -1; first_rd = -1; last_rd = -1;
    first_addr = -1; last_addr = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      bus.req = 1'b0;
      if (bus.rd_en === 1'b1) begin
        ea = (y*5 + rd_cnt/5)*160 + x*5 + rd_cnt%5;
        if (rd_cnt == 0) begin first_rd = k; first_addr = int'(bus.rd_addr); end
        last_rd = k; last_addr = int'(bus.rd_addr);
        if (bus.rd_addr !== ea[14:0]) addr_bad++;
        rd_cnt++;
      end
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.done === 1'b1) begin
        done_cyc = k;
        r_wall = bus.wall_count; r_nz = bus.nonzero_count; r_mask = bus.cell_mask;
        r_iswall = bus.is_wall; r_rerr = bus.range_err;
        break;
      end
    end
    @(negedge clock);
    post_done = bus.done; post_wall = bus.wall_count;
  endtask

  task automatic test_reset;
    bus.req = 1'b0; bus.x_in = '0; bus.y_in = '0;
    fill(3'b000);
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({bus.rd_en, bus.busy, bus.done, bus.range_err, bus.is_wall} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {bus.rd_en, bus.busy, bus.done, bus.range_err, bus.is_wall});
    end
    checks++;
    if ({bus.rd_addr, bus.wall_count, bus.nonzero_count, bus.cell_mask} !== 50'd0) begin
      errors++; $display("FAIL reset_data: addr %0d wall %0d nz %0d mask %h expected all 0",
                         bus.rd_addr, bus.wall_count, bus.nonzero_count, bus.cell_mask);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_zero;
    fill(3'b000);
    do_scan(0, 0);
    checks++; if (done_cyc !== 27) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 27", done_cyc); end
    checks++; if (rd_cnt !== 25 || first_rd !== 1 || last_rd !== 25) begin
      errors++; $display("FAIL zero_rd_window: count %0d first %0d last %0d expected 25 1 25", rd_cnt, first_rd, last_rd); end
    checks++; if (addr_bad !== 0) begin errors++; $display("FAIL zero_addr_seq: got %0d bad addresses expected 0", addr_bad); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL zero_busy: got %0d low cycles expected 0", busy_bad); end
    checks++; if ({r_wall, r_nz, r_iswall, r_rerr} !== 12'd0) begin
      errors++; $display("FAIL zero_results: wall %0d nz %0d is_wall %0d rerr %0d expected 0 0 0 0", r_wall, r_nz, r_iswall, r_rerr); end
    checks++; if (post_done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %0d expected 0", post_done); end
  endtask

  task automatic test_all_wall;
    logic [24:0] em;
    fill(3'b001);
    do_scan(31, 23);
`ifdef CELL_READER_MASK_EN
    em = 25'h1FFFFFF;
`else
    em = 25'd0;
`endif
    checks++; if (first_addr !== 18555 || last_addr !== 19199) begin
      errors++; $display("FAIL wall_addr_range: first %0d last %0d expected 18555 19199", first_addr, last_addr); end
    checks++; if (addr_bad !== 0) begin errors++; $display("FAIL wall_addr_seq: got %0d bad expected 0", addr_bad); end
    checks++; if (r_wall !== 5'd25 || r_nz !== 5'd25 || r_iswall !== 1'b1) begin
      errors++; $display("FAIL wall_counts: wall %0d nz %0d is_wall %0d expected 25 25 1", r_wall, r_nz, r_iswall); end
    checks++; if (r_mask !== em) begin errors++; $display("FAIL wall_mask: got %h expected %h", r_mask, em); end
    checks++; if (post_wall !== 5'd25) begin errors++; $display("FAIL wall_hold: got %0d expected 25", post_wall); end
  endtask

  task automatic test_pattern;
    logic [24:0] pat, em;
    pat = 25'b0111011111110001111101110;
    fill(3'b001);
    set_cell(4, 3, pat, 3'b110);
    do_scan(4, 3);
`ifdef CELL_READER_MASK_EN
    em = pat;
`else
    em = 25'd0;
`endif
    checks++; if (r_nz !== 5'd18 || r_wall !== 5'd0 || r_iswall !== 1'b0) begin
      errors++; $display("FAIL pattern_counts: nz %0d wall %0d is_wall %0d expected 18 0 0", r_nz, r_wall, r_iswall); end
    checks++; if (r_mask !== em) begin errors++; $display("FAIL pattern_mask: got %b expected %b", r_mask, em); end
  endtask

  task automatic test_threshold;
    logic [24:0] em;
    fill(3'b000);
    set_cell(10, 7, 25'h1FFE000, 3'b001);
    do_scan(10, 7);
    checks++; if (r_wall !== 5'd12 || r_nz !== 5'd12 || r_iswall !== 1'b0) begin
      errors++; $display("FAIL thresh_12: wall %0d nz %0d is_wall %0d expected 12 12 0", r_wall, r_nz, r_iswall); end
    set_cell(10, 7, 25'h1FFF000, 3'b001);
    do_scan(10, 7);
`ifdef CELL_READER_MASK_EN
    em = 25'h1FFF000;
`else
    em = 25'd0;
`endif
    checks++; if (r_wall !== 5'd13 || r_nz !== 5'd13 || r_iswall !== 1'b1) begin
      errors++; $display("FAIL thresh_13: wall %0d nz %0d is_wall %0d expected 13 13 1", r_wall, r_nz, r_iswall); end
    checks++; if (r_mask !== em) begin errors++; $display("FAIL thresh_mask: got %h expected %h", r_mask, em); end
  endtask

  task automatic test_range;
    do_scan(32, 5);
    checks++; if (done_cyc !== 1 || rd_cnt !== 0 || busy_bad !== 0) begin
      errors++; $display("FAIL range_x_timing: done %0d reads %0d busy_low %0d expected 1 0 0", done_cyc, rd_cnt, busy_bad); end
    checks++; if (r_rerr !== 1'b1 || r_iswall !== 1'b1 || r_wall !== 5'd0 || r_nz !== 5'd0 || r_mask !== 25'd0) begin
      errors++; $display("FAIL range_x_results: rerr %0d is_wall %0d wall %0d nz %0d mask %h expected 1 1 0 0 0",
                         r_rerr, r_iswall, r_wall, r_nz, r_mask); end
    do_scan(0, 24);
    checks++; if (done_cyc !== 1 || rd_cnt !== 0) begin
      errors++; $display("FAIL range_y_timing: done %0d reads %0d expected 1 0", done_cyc, rd_cnt); end
    checks++; if (r_rerr !== 1'b1 || r_iswall !== 1'b1 || r_wall !== 5'd0 || r_nz !== 5'd0) begin
      errors++; $display("FAIL range_y_results: rerr %0d is_wall %0d wall %0d nz %0d expected 1 1 0 0", r_rerr, r_iswall, r_wall, r_nz); end
  endtask

  task automatic test_back_to_back;
    int d1, d2, nrd;
    fill(3'b000);
    d1 = -1; d2 = -1; nrd = 0;
    @(negedge clock);
    bus.req = 1'b1; bus.x_in = 8'd0; bus.y_in = 7'd0;
    @(posedge clock);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clock);
      if (bus.rd_en === 1'b1) nrd++;
      if (bus.done === 1'b1) begin
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
      if (k == 55) bus.req = 1'b0;
      if (k == 55) break;
    end
    bus.req = 1'b0;
    checks++; if (d1 !== 27 || d2 !== 55) begin
      errors++; $display("FAIL b2b_done_cycles: got %0d %0d expected 27 55", d1, d2); end
    checks++; if (nrd !== 50) begin errors++; $display("FAIL b2b_reads: got %0d expected 50", nrd); end
    repeat (35) @(posedge clock);
  endtask

  task automatic test_mid_reset;
    int ndone;
    fill(3'b001);
    @(negedge clock);
    bus.req = 1'b1; bus.x_in = 8'd2; bus.y_in = 7'd2;
    @(posedge clock);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      bus.req = 1'b0;
      if (k == 10) reset_n = 1'b0;
    end
    @(negedge clock);
    checks++;
    if ({bus.rd_en, bus.busy, bus.done, bus.range_err, bus.is_wall} !== 5'b0) begin
      errors++; $display("FAIL midrst_ctrl: got %b expected 00000", {bus.rd_en, bus.busy, bus.done, bus.range_err, bus.is_wall});
    end
    checks++;
    if ({bus.rd_addr, bus.wall_count, bus.nonzero_count, bus.cell_mask} !== 50'd0) begin
      errors++; $display("FAIL midrst_data: addr %0d wall %0d nz %0d mask %h expected all 0",
                         bus.rd_addr, bus.wall_count, bus.nonzero_count, bus.cell_mask);
    end
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", ndone); end
    do_scan(2, 2);
    checks++; if (done_cyc !== 27 || rd_cnt !== 25 || addr_bad !== 0) begin
      errors++; $display("FAIL midrst_rescan_timing: done %0d reads %0d bad %0d expected 27 25 0", done_cyc, rd_cnt, addr_bad); end
    checks++; if (r_wall !== 5'd25 || r_nz !== 5'd25 || r_iswall !== 1'b1 || r_rerr !== 1'b0) begin
      errors++; $display("FAIL midrst_rescan_results: wall %0d nz %0d is_wall %0d rerr %0d expected 25 25 1 0",
                         r_wall, r_nz, r_iswall, r_rerr); end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_all_wall;
    test_pattern;
    test_threshold;
    test_range;
    test_back_to_back;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
